// File: rtl/fma_write_buffer.sv
// fma_write_buffer: packs three consecutive FMA result vectors into one
// "a b c per FMA" memory line and queues finished lines in a show-ahead FIFO
// that the memory block drains through its write-buffer read interface.
//
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   fma_result_in            FMA_COUNT result words, word 0 in the MSBs
//   fma_result_valid_in      result vector valid this cycle
//   flush_in                 push the partially packed line, zero-padded
//   read_req_in              memory consumes the head line this cycle
//   write_buffer_read_out    head line (0 when empty)
//   write_buffer_valid_out   FIFO non-empty
//   fma_ready_out            next valid beat will be accepted
//   count_out                lines currently queued
//   overflow_out             sticky: a completed or flushed line was dropped
module fma_write_buffer #(
  parameter int unsigned FMA_COUNT  = 2,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 96,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [FMA_COUNT*WORD_WIDTH-1:0]  fma_result_in,
  input  logic                             fma_result_valid_in,
  input  logic                             flush_in,
  input  logic                             read_req_in,
  output logic [LINE_WIDTH-1:0]            write_buffer_read_out,
  output logic                             write_buffer_valid_out,
  output logic                             fma_ready_out,
  output logic [$clog2(DEPTH+1)-1:0]       count_out,
  output logic                             overflow_out
);

  localparam int unsigned VEC_W = FMA_COUNT * WORD_WIDTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [1:0]            beat_q, beat_d;
  logic [LINE_WIDTH-1:0] part_q, part_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [LINE_WIDTH-1:0] mem_q [DEPTH];

  logic                  empty, full, pop, push, push_ok;
  logic [LINE_WIDTH-1:0] line_w, push_line;

  assign empty         = (count_q == '0);
  assign full          = (count_q == CNT_W'(DEPTH));
  assign pop           = read_req_in && !empty;
  assign fma_ready_out = !(full && (beat_q == 2'd2) && !read_req_in);

  // Partial line with the incoming beat dropped into slots 3*i+beat.
  always_comb begin
    line_w = part_q;
    for (int i = 0; i < FMA_COUNT; i++) begin
      line_w[LINE_WIDTH-1-(3*i+int'(beat_q))*WORD_WIDTH -: WORD_WIDTH] =
        fma_result_in[VEC_W-1-i*WORD_WIDTH -: WORD_WIDTH];
    end
  end

  // Packer and flush decisions, push/pop bookkeeping.
  always_comb begin
    beat_d    = beat_q;
    part_d    = part_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_line = line_w;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (fma_result_valid_in) begin
      if (beat_q == 2'd2) begin
        if (fma_ready_out) begin
          push   = 1'b1;
          beat_d = 2'd0;
          part_d = '0;
        end else begin
          // Completing beat refused; producer may retry unless a flush clears.
          ovf_d = 1'b1;
          if (flush_in) begin
            beat_d = 2'd0;
            part_d = '0;
          end
        end
      end else if (flush_in) begin
        push   = 1'b1;
        beat_d = 2'd0;
        part_d = '0;
      end else begin
        part_d = line_w;
        beat_d = beat_q + 2'd1;
      end
    end else if (flush_in && (beat_q != 2'd0)) begin
      push      = 1'b1;
      push_line = part_q;
      beat_d    = 2'd0;
      part_d    = '0;
    end

    // A pop in the same cycle frees the slot even when full.
    push_ok = push && (!full || pop);
    if (push && !push_ok) ovf_d = 1'b1;

    if (push_ok) tail_d = tail_q + PTR_W'(1);
    if (pop)     head_d = head_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
  end

  // State registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      beat_q  <= 2'd0;
      part_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      part_q  <= part_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Line storage; contents are only observed while counted as valid.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_ok) mem_q[tail_q] <= push_line;
  end

  always_comb begin
    write_buffer_read_out = '0;
    if (!empty) write_buffer_read_out = mem_q[head_q];
  end

  assign write_buffer_valid_out = !empty;
  assign count_out              = count_q;
  assign overflow_out           = ovf_q;

endmodule

// File: tb/tb_fma_write_buffer.sv
// Bench for fma_write_buffer: directed steps plus random traffic, checked
// against a queue-based model that keeps accepted beats as a list.
module tb_fma_write_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] fma_result_in;
  logic        fma_result_valid_in;
  logic        flush_in;
  logic        read_req_in;
  logic [95:0] write_buffer_read_out;
  logic        write_buffer_valid_out;
  logic        fma_ready_out;
  logic [2:0]  count_out;
  logic        overflow_out;

  int errors = 0;
  int checks = 0;

  // Model state: queued lines, beats collected for the current line, sticky flag.
  logic [95:0] lines[$];
  logic [31:0] beats[$];
  bit          ovf_m;

  fma_write_buffer dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .fma_result_in          (fma_result_in),
    .fma_result_valid_in    (fma_result_valid_in),
    .flush_in               (flush_in),
    .read_req_in            (read_req_in),
    .write_buffer_read_out  (write_buffer_read_out),
    .write_buffer_valid_out (write_buffer_valid_out),
    .fma_ready_out          (fma_ready_out),
    .count_out              (count_out),
    .overflow_out           (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line built from the beat list: beat k word i lands in slot 3*i+k.
  function automatic logic [95:0] build_line();
    logic [95:0] l = '0;
    for (int k = 0; k < beats.size(); k++)
      for (int i = 0; i < 2; i++)
        l[95-(3*i+k)*16 -: 16] = beats[k][31-16*i -: 16];
    return l;
  endfunction

  task automatic check_outputs();
    logic [95:0] head = (lines.size() != 0) ? lines[0] : 96'd0;
    bit ready = !(lines.size() == 4 && beats.size() == 2 && !read_req_in);
    chk("count", 96'(count_out), 96'(lines.size()));
    chk("valid", 96'(write_buffer_valid_out), 96'(lines.size() != 0));
    chk("head", write_buffer_read_out, head);
    chk("ready", 96'(fma_ready_out), 96'(ready));
    chk("overflow", 96'(overflow_out), 96'(ovf_m));
  endtask

  task automatic model_edge();
    bit          pop, room, want;
    logic [95:0] l;
    if (rst_in) begin
      lines.delete(); beats.delete(); ovf_m = 1'b0;
      return;
    end
    pop  = read_req_in && lines.size() != 0;
    room = lines.size() < 4 || pop;
    want = 1'b0;
    if (fma_result_valid_in && !(beats.size() == 2 && !room)) begin
      beats.push_back(fma_result_in);
      if (beats.size() == 3 || flush_in) begin
        want = 1'b1; l = build_line(); beats.delete();
      end
    end else if (fma_result_valid_in) begin
      ovf_m = 1'b1;
      if (flush_in) beats.delete();
    end else if (flush_in && beats.size() != 0) begin
      want = 1'b1; l = build_line(); beats.delete();
    end
    if (pop) void'(lines.pop_front());
    if (want) begin
      if (room) lines.push_back(l);
      else ovf_m = 1'b1;
    end
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit f, input bit r, input bit rst = 1'b0);
    @(negedge clk_in);
    rst_in = rst; fma_result_valid_in = v; fma_result_in = d;
    flush_in = f; read_req_in = r;
    #1 check_outputs();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  initial begin
    // Reset held two cycles with valid asserted.
    rst_in = 1'b1; fma_result_valid_in = 1'b1; fma_result_in = 32'hDEAD_BEEF;
    flush_in = 1'b0; read_req_in = 1'b0;
    repeat (2) @(posedge clk_in);
    model_edge();
    #1;
    chk("rst_count", 96'(count_out), 96'd0);
    chk("rst_valid", 96'(write_buffer_valid_out), 96'd0);
    chk("rst_head", write_buffer_read_out, 96'd0);
    chk("rst_ovf", 96'(overflow_out), 96'd0);
    chk("rst_ready", 96'(fma_ready_out), 96'd1);

    // Packing.
    step(1, 32'h0001_0002, 0, 0);
    step(1, 32'h0003_0004, 0, 0);
    step(1, 32'h0005_0006, 0, 0);
    chk("pack_line", write_buffer_read_out, 96'h0001_0003_0005_0002_0004_0006);
    chk("pack_count", 96'(count_out), 96'd1);

    // Pop, then pop while empty.
    step(0, 0, 0, 1);
    chk("pop_count", 96'(count_out), 96'd0);
    chk("pop_head", write_buffer_read_out, 96'd0);
    step(0, 0, 0, 1);
    chk("pop_empty_valid", 96'(write_buffer_valid_out), 96'd0);

    // Flush of a single beat, then a no-op flush.
    step(1, 32'h00AA_00BB, 0, 0);
    step(0, 0, 1, 0);
    chk("flush_line", write_buffer_read_out, 96'h00AA_0000_0000_00BB_0000_0000);
    step(0, 0, 1, 0);
    chk("flush_noop_count", 96'(count_out), 96'd1);
    step(0, 0, 0, 1);

    // Fill, refuse the completing beat, then retry alongside a pop.
    for (int n = 0; n < 12; n++) step(1, $urandom, 0, 0);
    step(1, 32'h1111_2222, 0, 0);
    step(1, 32'h3333_4444, 0, 0);
    step(1, 32'h5555_6666, 0, 0);
    chk("full_ovf", 96'(overflow_out), 96'd1);
    chk("full_count", 96'(count_out), 96'd4);
    step(1, 32'h5555_6666, 0, 1);
    chk("full_retry_count", 96'(count_out), 96'd4);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 1);
    chk("drain_count", 96'(count_out), 96'd0);

    // Ten lines through the pointers.
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 3; k++) step(1, {16'(n*16+k), 16'(n*16+k+8)}, 0, 0);
      step(0, 0, 0, 1);
    end

    // Reset mid-run, then a fresh line.
    for (int n = 0; n < 7; n++) step(1, $urandom, 0, 0);
    step(1, $urandom, 0, 0, 1);
    chk("midrst_count", 96'(count_out), 96'd0);
    chk("midrst_ovf", 96'(overflow_out), 96'd0);
    step(1, 32'h0011_0022, 0, 0);
    step(1, 32'h0033_0044, 0, 0);
    step(1, 32'h0055_0066, 0, 0);
    chk("midrst_line", write_buffer_read_out, 96'h0011_0033_0055_0022_0044_0066);
    chk("midrst_line_count", 96'(count_out), 96'd1);

    // Random traffic.
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);

    @(negedge clk_in);
    fma_result_valid_in = 1'b0; flush_in = 1'b0; read_req_in = 1'b0; rst_in = 1'b0;
    #1 check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fma_write_buffer.md
Name: fma_write_buffer

Overview:
- Return path from the FMA array to the memory block.
- Collects per-cycle FMA result vectors and packs three consecutive vectors into one memory line. The line uses the same "a b c per FMA" layout the memory block uses for abc lines.
- Queues completed lines in a small show-ahead FIFO.
- Presents the FIFO head on the memory block's write_buffer_read_in / write_buffer_valid_in interface. The memory pops a line when it executes a store-from-buffer instruction.

Parameters:
- FMA_COUNT, 2, number of FMAs producing one result word each per beat.
- WORD_WIDTH, 16, bits per word.
- LINE_WIDTH, 96, bits per line; must equal FMA_COUNT*3*WORD_WIDTH.
- DEPTH, 4, number of completed lines the FIFO holds; power of two, >= 2.

Ports:
- clk_in  input  1  system clock, all logic on rising edge.
- rst_in  input  1  synchronous active-high reset.
- fma_result_in  input  FMA_COUNT*WORD_WIDTH  result vector; word i at bits [FMA_COUNT*WORD_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH].
- fma_result_valid_in  input  1  fma_result_in valid this cycle.
- flush_in  input  1  push the partially packed line, zero-padded.
- read_req_in  input  1  memory consumes the head line this cycle.
- write_buffer_read_out  output  LINE_WIDTH  head line (connects to memory write_buffer_read_in).
- write_buffer_valid_out  output  1  FIFO non-empty (connects to memory write_buffer_valid_in).
- fma_ready_out  output  1  next valid beat will be accepted.
- count_out  output  $clog2(DEPTH+1)  number of lines in the FIFO.
- overflow_out  output  1  sticky: a line was dropped.

Behaviour:
- Reset (rst_in high at a clock edge, synchronous active-high)
  - Clears packer: beat_idx=0, partial line=0.
  - Clears FIFO: head=tail=0, count_out=0, write_buffer_valid_out=0, write_buffer_read_out=0.
  - Clears overflow_out=0; fma_ready_out=1 from the first cycle after reset.
  - Reset mid-operation discards all partial and queued data. Reset has priority over every other input.
- Packer
  - Two-bit beat_idx counts 0, 1, 2.
  - An accepted beat with beat_idx=k writes word i of fma_result_in into line word slot 3*i+k.
  - Slot s occupies bits [LINE_WIDTH-1-s*WORD_WIDTH -: WORD_WIDTH]. Beat 0 therefore fills the "a" words, beat 1 the "b" words, beat 2 the "c" words.
  - Beats 0 and 1 are always accepted and beat_idx increments.
  - Beat 2 completes the line. The full line is pushed into the FIFO the same edge, beat_idx returns to 0 and the partial register is cleared.
- FIFO
  - Circular, DEPTH entries, wrap at DEPTH.
  - Show-ahead: write_buffer_read_out always equals the head entry (0 when empty); write_buffer_valid_out = (count_out != 0).
  - A pop occurs on read_req_in && write_buffer_valid_out. The head advances at that edge, so new head data is visible the next cycle.
  - read_req_in while empty is ignored; no state change.
  - Push and pop in the same cycle, including when full: both happen and count_out is unchanged.
- Ready and overflow
  - fma_ready_out = !(count_out==DEPTH && beat_idx==2 && !read_req_in).
  - A valid beat 2 arriving while fma_ready_out=0 is dropped. beat_idx and the partial line stay unchanged (the producer may retry) and overflow_out sets.
  - overflow_out stays high until reset.
- Flush
  - On flush_in with beat_idx!=0, the partial line is pushed with unfilled slots zero, then beat_idx=0.
  - If a valid beat arrives the same cycle, it is packed first:
    - beat_idx 0 or 1 → line pushed containing that beat.
    - beat_idx 2 → normal completion; the flush has nothing further to push.
  - Flush with beat_idx=0 and no valid beat is a no-op.
  - A flush push into a full FIFO without a same-cycle pop is dropped and sets overflow_out. The packer still clears.
- Latency
  - A completed or flushed line is visible on write_buffer_read_out and write_buffer_valid_out one cycle after the completing edge, when the FIFO was empty.

Test Plan:
- Reset: assert rst_in 2 cycles with fma_result_valid_in=1 → count_out=0, write_buffer_valid_out=0, write_buffer_read_out=0, overflow_out=0, fma_ready_out=1.
- Packing: beats {0x0001,0x0002}, {0x0003,0x0004}, {0x0005,0x0006} on 3 consecutive cycles → next cycle write_buffer_valid_out=1, write_buffer_read_out=96'h0001_0003_0005_0002_0004_0006, count_out=1.
- Pop: from above, pulse read_req_in one cycle → next cycle write_buffer_valid_out=0, count_out=0, write_buffer_read_out=0. A second read_req_in while empty → no change.
- Flush: one beat {0x00AA,0x00BB}, then flush_in → line 96'h00AA_0000_0000_00BB_0000_0000 queued. Flush again with beat_idx=0 → count_out unchanged.
- Full and overflow: fill 4 lines (12 beats, no reads), send 2 more beats → fma_ready_out=0. 3rd beat is dropped and overflow_out=1, count_out=4, and FIFO contents are intact when popped in order. Repeat the 3rd beat with read_req_in=1 → accepted, count_out stays 4.
- Wrap and reset mid-run: push and pop 10 lines with distinct values → output order matches input order across pointer wrap. Assert rst_in with 2 lines queued and beat_idx=1 → all cleared; next 3 beats form a fresh line.
